// File: rtl/hex_display_pkg.sv
// Shared seven-segment definitions for the hex display driver and capture logic.
package hex_display_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  // Decoded segment pattern; ok is low for an undecodable, non-blank pattern.
  typedef struct packed {
    logic    ok;
    logic    blank;
    nibble_t nibble;
  } seg_dec_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam seg_t SEG_ENC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Map a segment pattern back to {ok, blank, nibble}; blank and bad patterns read 0.
  function automatic seg_dec_t seg_to_nibble(input seg_t seg);
    seg_dec_t r;
    r = '0;
    if (seg == SEG_BLANK) begin
      r.ok    = 1'b1;
      r.blank = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg == SEG_ENC[i]) begin
          r.ok     = 1'b1;
          r.nibble = nibble_t'(i);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_display_capture_in_sync_settle.sv
// Two-flop synchronizer followed by a settle counter; strobes once per stable sample.
module in_sync_settle #(
  parameter int unsigned W             = 15,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic         settled_c,
  output logic [W-1:0] dout
);

  localparam int unsigned CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_TOP = CW'(SETTLE_CYCLES - 1);

  logic [W-1:0]  sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acted_q, acted_d;
  logic          same_c;

  assign same_c    = (sync2_q == prev_q);
  assign settled_c = same_c && (cnt_q == CNT_TOP) && !acted_q;
  assign dout      = sync2_q;

  // Count identical consecutive samples and allow a single strobe per stable run.
  always_comb begin
    cnt_d   = '0;
    acted_d = acted_q;
    if (same_c) begin
      cnt_d = (cnt_q == CNT_TOP) ? cnt_q : CW'(cnt_q + 1'b1);
      if (settled_c) acted_d = 1'b1;
    end else begin
      acted_d = 1'b0;
    end
  end

  // Synchronizer, previous-sample and settle state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      acted_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      acted_q <= acted_d;
    end
  end

endmodule

// File: rtl/hex_display_capture.sv
// Rebuilds the hex value shown on a scanned seven-segment display and publishes stable frames.
module hex_display_capture
  import hex_display_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 8,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic [6:0]            Segments,
  input  logic [N_DIGITS-1:0]   Anodes,
  output logic [4*N_DIGITS-1:0] value,
  output logic [N_DIGITS-1:0]   blank_mask,
  output logic                  frame_valid,
  output logic                  digit_err,
  output logic                  anode_err
);

  localparam int unsigned SW = 7;
  localparam int unsigned DW = SW + N_DIGITS;
  localparam int unsigned VW = 4 * N_DIGITS;
  localparam int unsigned MW = 4;
  localparam logic [MW-1:0] MATCH_MAX = '1;
  localparam logic [MW-1:0] STABLE_M  = MW'(STABLE_FRAMES);

  logic               settled_c;
  logic [DW-1:0]      settled_data;
  seg_t               seg;
  logic [N_DIGITS-1:0] an;
  seg_dec_t           dec;
  int unsigned        low_cnt;
  logic               frame_eq;

  logic [N_DIGITS-1:0] seen_q, seen_d;
  logic [VW-1:0]       frame_nib_q, frame_nib_d;
  logic [N_DIGITS-1:0] frame_blk_q, frame_blk_d;
  logic [VW-1:0]       prev_nib_q, prev_nib_d;
  logic [N_DIGITS-1:0] prev_blk_q, prev_blk_d;
  logic [MW-1:0]       match_q, match_d;
  logic [VW-1:0]       value_d;
  logic [N_DIGITS-1:0] blank_mask_d;
  logic                frame_valid_d, digit_err_d, anode_err_d;

  in_sync_settle #(
    .W             (DW),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_in_sync_settle (
    .clk       (Clk),
    .rst_n     (reset),
    .din       ({Anodes, Segments}),
    .settled_c (settled_c),
    .dout      (settled_data)
  );

  assign seg = settled_data[SW-1:0];
  assign an  = settled_data[DW-1:SW];
  assign dec = seg_to_nibble(seg);

  // Number of active (low) digit enables in the settled sample.
  always_comb begin
    low_cnt = 0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (!an[i]) low_cnt = low_cnt + 1;
    end
  end

  // Frame assembly, repeat matching and acceptance.
  always_comb begin
    seen_d        = seen_q;
    frame_nib_d   = frame_nib_q;
    frame_blk_d   = frame_blk_q;
    prev_nib_d    = prev_nib_q;
    prev_blk_d    = prev_blk_q;
    match_d       = match_q;
    value_d       = value;
    blank_mask_d  = blank_mask;
    frame_valid_d = 1'b0;
    digit_err_d   = 1'b0;
    anode_err_d   = 1'b0;
    frame_eq      = 1'b0;
    if (settled_c) begin
      if (low_cnt == 1) begin
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
          if (!an[i]) begin
            frame_nib_d[4*i +: 4] = dec.nibble;
            frame_blk_d[i]        = dec.blank;
            seen_d[i]             = 1'b1;
          end
        end
        digit_err_d = !dec.ok;
        if (&seen_d) begin
          seen_d   = '0;
          frame_eq = (frame_nib_d == prev_nib_q) && (frame_blk_d == prev_blk_q);
          if (frame_eq) begin
            match_d = (match_q == MATCH_MAX) ? match_q : MW'(match_q + 1'b1);
          end else begin
            match_d    = MW'(1);
            prev_nib_d = frame_nib_d;
            prev_blk_d = frame_blk_d;
          end
          // A saturated counter on an identical frame has already been published.
          if ((match_d == STABLE_M) && !(frame_eq && (match_q == MATCH_MAX))) begin
            value_d       = frame_nib_d;
            blank_mask_d  = frame_blk_d;
            frame_valid_d = 1'b1;
          end
        end
      end else if (low_cnt > 1) begin
        anode_err_d = 1'b1;
        seen_d      = '0;
      end
    end
  end

  // Frame buffers, match counter and registered outputs.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      seen_q      <= '0;
      frame_nib_q <= '0;
      frame_blk_q <= '0;
      prev_nib_q  <= '0;
      prev_blk_q  <= '0;
      match_q     <= '0;
      value       <= '0;
      blank_mask  <= '1;
      frame_valid <= 1'b0;
      digit_err   <= 1'b0;
      anode_err   <= 1'b0;
    end else begin
      seen_q      <= seen_d;
      frame_nib_q <= frame_nib_d;
      frame_blk_q <= frame_blk_d;
      prev_nib_q  <= prev_nib_d;
      prev_blk_q  <= prev_blk_d;
      match_q     <= match_d;
      value       <= value_d;
      blank_mask  <= blank_mask_d;
      frame_valid <= frame_valid_d;
      digit_err   <= digit_err_d;
      anode_err   <= anode_err_d;
    end
  end

endmodule

// File: tb/tb_hex_display_capture.sv
// Self-checking bench for hex_display_capture with a frame-level reference model.
module tb_hex_display_capture;

  localparam int STABLE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Segments;
  logic [7:0]  Anodes;
  logic [31:0] value;
  logic [7:0]  blank_mask;
  logic        frame_valid, digit_err, anode_err;

  int checks = 0;
  int errors = 0;

  // Pulse counters from the monitor.
  int fv_cnt = 0;
  int de_cnt = 0;
  int ae_cnt = 0;

  // Reference model state.
  logic [31:0] m_prev_nib;
  logic [7:0]  m_prev_blk;
  int          m_cnt;
  int          m_pulses;
  logic [31:0] m_value;
  logic [7:0]  m_blank;
  int          m_derr;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  hex_display_capture dut (
    .Clk         (clk),
    .reset       (reset),
    .Segments    (Segments),
    .Anodes      (Anodes),
    .value       (value),
    .blank_mask  (blank_mask),
    .frame_valid (frame_valid),
    .digit_err   (digit_err),
    .anode_err   (anode_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (frame_valid) fv_cnt++;
      if (digit_err)   de_cnt++;
      if (anode_err)   ae_cnt++;
    end
  end

  task automatic model_reset();
    m_prev_nib = '0;
    m_prev_blk = '0;
    m_cnt      = 0;
    m_pulses   = 0;
    m_value    = '0;
    m_blank    = 8'hFF;
    m_derr     = 0;
  endtask

  // A completed frame: count identical repeats, publish when the count first hits STABLE.
  task automatic model_frame(input logic [31:0] nib, input logic [7:0] blk);
    if (nib == m_prev_nib && blk == m_prev_blk) begin
      if (m_cnt < 15) begin
        m_cnt++;
        if (m_cnt == STABLE) begin
          m_pulses++; m_value = nib; m_blank = blk;
        end
      end
    end else begin
      m_prev_nib = nib; m_prev_blk = blk; m_cnt = 1;
      if (STABLE == 1) begin
        m_pulses++; m_value = nib; m_blank = blk;
      end
    end
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    Anodes   = 8'hFF;
    Segments = 7'h7F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic drive_digit(input int idx, input logic [6:0] seg, input int hold);
    @(posedge clk); #1;
    Anodes      = 8'hFF;
    Anodes[idx] = 1'b0;
    Segments    = seg;
    repeat (hold - 1) @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    Anodes   = 8'hFF;
    Segments = 7'h7F;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full scan of digits 0..7; hold 0 picks a random per-digit hold time.
  task automatic scan(input logic [31:0] hexv, input logic [7:0] blk,
                      input logic [7:0] bad, input int hold);
    logic [31:0] exp_nib;
    logic [3:0]  n;
    logic [6:0]  seg;
    int          h;
    exp_nib = '0;
    for (int i = 0; i < 8; i++) begin
      n = hexv[4*i +: 4];
      if (blk[i])      seg = 7'h7F;
      else if (bad[i]) seg = 7'h55;
      else begin
        seg = seg_tab[n];
        exp_nib[4*i +: 4] = n;
      end
      h = (hold > 0) ? hold : int'($urandom_range(8, 20));
      drive_digit(i, seg, h);
    end
    model_frame(exp_nib, blk & ~bad);
    m_derr += $countones(bad & ~blk);
  endtask

  task automatic test_reset();
    int fv0, de0, ae0;
    apply_reset();
    fv0 = fv_cnt; de0 = de_cnt; ae0 = ae_cnt;
    idle(30);
    checks++; if (value !== 32'h0) begin errors++; $display("FAIL reset_value got %h want %h", value, 32'h0); end
    checks++; if (blank_mask !== 8'hFF) begin errors++; $display("FAIL reset_blank got %h want ff", blank_mask); end
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL reset_fv got %0d want 0", fv_cnt - fv0); end
    checks++; if ((de_cnt - de0) + (ae_cnt - ae0) !== 0) begin errors++; $display("FAIL reset_errs got %0d want 0", (de_cnt - de0) + (ae_cnt - ae0)); end
  endtask

  task automatic test_basic();
    int fv0;
    apply_reset();
    fv0 = fv_cnt;
    scan(32'h0000_0015, 8'h00, 8'h00, 20);
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL basic_first_scan got %0d pulses want 0", fv_cnt - fv0); end
    scan(32'h0000_0015, 8'h00, 8'h00, 20);
    idle(10);
    checks++; if (fv_cnt - fv0 !== m_pulses) begin errors++; $display("FAIL basic_fv got %0d want %0d", fv_cnt - fv0, m_pulses); end
    checks++; if (value !== m_value) begin errors++; $display("FAIL basic_value got %h want %h", value, m_value); end
    checks++; if (blank_mask !== m_blank) begin errors++; $display("FAIL basic_blank got %h want %h", blank_mask, m_blank); end
  endtask

  task automatic test_blank();
    int fv0;
    apply_reset();
    fv0 = fv_cnt;
    repeat (2) scan(32'h0000_0021, 8'hFC, 8'h00, 20);
    idle(10);
    checks++; if (fv_cnt - fv0 !== m_pulses) begin errors++; $display("FAIL blank_fv got %0d want %0d", fv_cnt - fv0, m_pulses); end
    checks++; if (value !== m_value) begin errors++; $display("FAIL blank_value got %h want %h", value, m_value); end
    checks++; if (blank_mask !== m_blank) begin errors++; $display("FAIL blank_mask got %h want %h", blank_mask, m_blank); end
  endtask

  task automatic test_stable_change();
    int fv0;
    apply_reset();
    fv0 = fv_cnt;
    repeat (2) scan(32'h1234_ABCD, 8'h00, 8'h00, 15);
    scan(32'h1234_ABCE, 8'h00, 8'h00, 15);
    idle(10);
    checks++; if (fv_cnt - fv0 !== 1) begin errors++; $display("FAIL change_single_fv got %0d want 1", fv_cnt - fv0); end
    checks++; if (value !== 32'h1234_ABCD) begin errors++; $display("FAIL change_hold_value got %h want 1234abcd", value); end
    scan(32'h1234_ABCE, 8'h00, 8'h00, 15);
    scan(32'h1234_ABCE, 8'h00, 8'h00, 15);
    idle(10);
    checks++; if (fv_cnt - fv0 !== m_pulses) begin errors++; $display("FAIL change_fv got %0d want %0d", fv_cnt - fv0, m_pulses); end
    checks++; if (value !== m_value) begin errors++; $display("FAIL change_value got %h want %h", value, m_value); end
  endtask

  task automatic test_latency();
    int lat;
    apply_reset();
    scan(32'h5555_5555, 8'h00, 8'h00, 20);
    for (int i = 0; i < 7; i++) drive_digit(i, seg_tab[5], 20);
    @(posedge clk); #1;
    Anodes   = 8'h7F;
    Segments = seg_tab[5];
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (frame_valid && lat == 0) lat = k;
    end
    checks++; if (lat !== 6) begin errors++; $display("FAIL latency got %0d cycles want 6", lat); end
    checks++; if (value !== 32'h5555_5555) begin errors++; $display("FAIL latency_value got %h want 55555555", value); end
  endtask

  task automatic test_anode_err();
    int fv0, ae0;
    apply_reset();
    fv0 = fv_cnt; ae0 = ae_cnt;
    for (int i = 0; i < 4; i++) drive_digit(i, seg_tab[i + 1], 15);
    @(posedge clk); #1;
    Anodes = 8'hFC;
    repeat (19) @(posedge clk);
    for (int i = 4; i < 8; i++) drive_digit(i, seg_tab[i + 1], 15);
    idle(10);
    checks++; if (ae_cnt - ae0 !== 1) begin errors++; $display("FAIL anode_err got %0d pulses want 1", ae_cnt - ae0); end
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL anode_discard got %0d pulses want 0", fv_cnt - fv0); end
    repeat (2) scan(32'h8765_4321, 8'h00, 8'h00, 15);
    idle(10);
    checks++; if (fv_cnt - fv0 !== m_pulses) begin errors++; $display("FAIL anode_recover_fv got %0d want %0d", fv_cnt - fv0, m_pulses); end
    checks++; if (value !== 32'h8765_4321) begin errors++; $display("FAIL anode_recover_value got %h want 87654321", value); end
  endtask

  task automatic test_digit_err();
    int fv0, de0;
    apply_reset();
    fv0 = fv_cnt; de0 = de_cnt;
    repeat (2) scan(32'hFEDC_BA98, 8'h00, 8'h08, 15);
    idle(10);
    checks++; if (de_cnt - de0 !== m_derr) begin errors++; $display("FAIL digit_err got %0d pulses want %0d", de_cnt - de0, m_derr); end
    checks++; if (fv_cnt - fv0 !== m_pulses) begin errors++; $display("FAIL digit_err_fv got %0d want %0d", fv_cnt - fv0, m_pulses); end
    checks++; if (value !== m_value) begin errors++; $display("FAIL digit_err_value got %h want %h", value, m_value); end
    checks++; if (blank_mask !== m_blank) begin errors++; $display("FAIL digit_err_blank got %h want %h", blank_mask, m_blank); end
  endtask

  task automatic test_glitch();
    int fv0, de0;
    logic [31:0] v;
    apply_reset();
    fv0 = fv_cnt; de0 = de_cnt;
    v = 32'h7654_3210;
    repeat (2) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 3) begin
          @(posedge clk); #1;
          Anodes = 8'hF7; Segments = 7'h55;
          @(posedge clk); #1;
          Segments = 7'h2A;
          @(posedge clk); #1;
          Segments = 7'h55;
          drive_digit(3, seg_tab[3], 15);
        end else begin
          drive_digit(i, seg_tab[i], 15);
        end
      end
      model_frame(v, 8'h00);
    end
    idle(10);
    checks++; if (de_cnt - de0 !== 0) begin errors++; $display("FAIL glitch_digit_err got %0d want 0", de_cnt - de0); end
    checks++; if (value !== m_value) begin errors++; $display("FAIL glitch_value got %h want %h", value, m_value); end
    checks++; if (fv_cnt - fv0 !== m_pulses) begin errors++; $display("FAIL glitch_fv got %0d want %0d", fv_cnt - fv0, m_pulses); end
  endtask

  task automatic test_reset_mid();
    int fv0;
    apply_reset();
    repeat (3) scan(32'h0BAD_F00D, 8'h00, 8'h00, 12);
    for (int i = 0; i < 3; i++) drive_digit(i, seg_tab[i], 12);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    checks++; if (value !== 32'h0) begin errors++; $display("FAIL async_reset_value got %h want 0", value); end
    checks++; if (blank_mask !== 8'hFF) begin errors++; $display("FAIL async_reset_blank got %h want ff", blank_mask); end
    checks++; if ({frame_valid, digit_err, anode_err} !== 3'b000) begin errors++; $display("FAIL async_reset_pulses got %b want 000", {frame_valid, digit_err, anode_err}); end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    fv0 = fv_cnt;
    scan(32'h0BAD_F00D, 8'h00, 8'h00, 12);
    idle(10);
    checks++; if (fv_cnt - fv0 !== 0) begin errors++; $display("FAIL restart_single got %0d pulses want 0", fv_cnt - fv0); end
    scan(32'h0BAD_F00D, 8'h00, 8'h00, 12);
    idle(10);
    checks++; if (value !== 32'h0BAD_F00D) begin errors++; $display("FAIL restart_value got %h want 0badf00d", value); end
  endtask

  task automatic test_random();
    int fv0, de0, reps;
    logic [31:0] hv;
    logic [7:0]  blk, bad;
    apply_reset();
    fv0 = fv_cnt; de0 = de_cnt;
    hv = '0; blk = '0; bad = '0;
    for (int it = 0; it < 12; it++) begin
      if (it == 0 || $urandom_range(0, 3) != 0) begin
        hv  = $urandom;
        blk = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        bad = ($urandom_range(0, 4) == 0) ? 8'($urandom) & ~blk : 8'h00;
      end
      reps = $urandom_range(1, 3);
      repeat (reps) scan(hv, blk, bad, 0);
      idle(8);
      checks++; if (value !== m_value || blank_mask !== m_blank) begin
        errors++; $display("FAIL random_iter%0d got %h/%h want %h/%h", it, value, blank_mask, m_value, m_blank);
      end
    end
    checks++; if (fv_cnt - fv0 !== m_pulses) begin errors++; $display("FAIL random_fv got %0d want %0d", fv_cnt - fv0, m_pulses); end
    checks++; if (de_cnt - de0 !== m_derr) begin errors++; $display("FAIL random_digit_err got %0d want %0d", de_cnt - de0, m_derr); end
  endtask

  initial begin
    reset    = 1'b0;
    Anodes   = 8'hFF;
    Segments = 7'h7F;
    test_reset();
    test_basic();
    test_blank();
    test_stable_change();
    test_latency();
    test_anode_err();
    test_digit_err();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
